md5_unround: RTL



---
 rtl/md5_unround_if.sv | 28 ++
 rtl/md5_unround.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_unround_if.sv
// Handshake and data bundle for the inverse MD5 compression engine.
// The requester owns start/ff_sub/state/message; the engine owns busy, done
// and the recovered state.
interface md5_unround_if;
    logic         start;
    logic         ff_sub;
    logic [31:0]  a_in;
    logic [31:0]  b_in;
    logic [31:0]  c_in;
    logic [31:0]  d_in;
    logic [511:0] msg;
    logic         busy;
    logic         done;
    logic [31:0]  a_out;
    logic [31:0]  b_out;
    logic [31:0]  c_out;
    logic [31:0]  d_out;

    modport master (
        output start, ff_sub, a_in, b_in, c_in, d_in, msg,
        input  busy, done, a_out, b_out, c_out, d_out
    );

    modport slave (
        input  start, ff_sub, a_in, b_in, c_in, d_in, msg,
        output busy, done, a_out, b_out, c_out, d_out
    );
endinterface

// File: rtl/md5_unround.sv
// Iterative inverse MD5 compression engine.
// Given the working state after step LAST_STEP (or a final digest when
// ff_sub=1) and the message block, it undoes one MD5 step per clock, walking
// the step index down to FIRST_STEP, and reports the state that existed
// before step FIRST_STEP.
module md5_unround #(
    parameter int unsigned LAST_STEP  = 63,
    parameter int unsigned FIRST_STEP = 0
) (
    input  logic          clk,
    input  logic          rst,
    md5_unround_if.slave  bus
);

    localparam logic [5:0]  LAST_K  = 6'(LAST_STEP);
    localparam logic [5:0]  FIRST_K = 6'(FIRST_STEP);

    // Standard MD5 initial chaining value, removed from a final digest.
    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Additive constant ROM: floor(|sin(k+1)| * 2^32).
    function automatic logic [31:0] k_const(input logic [5:0] k);
        logic [31:0] v;
        case (k)
            6'd0:  v = 32'hd76aa478;
            6'd1:  v = 32'he8c7b756;
            6'd2:  v = 32'h242070db;
            6'd3:  v = 32'hc1bdceee;
            6'd4:  v = 32'hf57c0faf;
            6'd5:  v = 32'h4787c62a;
            6'd6:  v = 32'ha8304613;
            6'd7:  v = 32'hfd469501;
            6'd8:  v = 32'h698098d8;
            6'd9:  v = 32'h8b44f7af;
            6'd10: v = 32'hffff5bb1;
            6'd11: v = 32'h895cd7be;
            6'd12: v = 32'h6b901122;
            6'd13: v = 32'hfd987193;
            6'd14: v = 32'ha679438e;
            6'd15: v = 32'h49b40821;
            6'd16: v = 32'hf61e2562;
            6'd17: v = 32'hc040b340;
            6'd18: v = 32'h265e5a51;
            6'd19: v = 32'he9b6c7aa;
            6'd20: v = 32'hd62f105d;
            6'd21: v = 32'h02441453;
            6'd22: v = 32'hd8a1e681;
            6'd23: v = 32'he7d3fbc8;
            6'd24: v = 32'h21e1cde6;
            6'd25: v = 32'hc33707d6;
            6'd26: v = 32'hf4d50d87;
            6'd27: v = 32'h455a14ed;
            6'd28: v = 32'ha9e3e905;
            6'd29: v = 32'hfcefa3f8;
            6'd30: v = 32'h676f02d9;
            6'd31: v = 32'h8d2a4c8a;
            6'd32: v = 32'hfffa3942;
            6'd33: v = 32'h8771f681;
            6'd34: v = 32'h6d9d6122;
            6'd35: v = 32'hfde5380c;
            6'd36: v = 32'ha4beea44;
            6'd37: v = 32'h4bdecfa9;
            6'd38: v = 32'hf6bb4b60;
            6'd39: v = 32'hbebfbc70;
            6'd40: v = 32'h289b7ec6;
            6'd41: v = 32'heaa127fa;
            6'd42: v = 32'hd4ef3085;
            6'd43: v = 32'h04881d05;
            6'd44: v = 32'hd9d4d039;
            6'd45: v = 32'he6db99e5;
            6'd46: v = 32'h1fa27cf8;
            6'd47: v = 32'hc4ac5665;
            6'd48: v = 32'hf4292244;
            6'd49: v = 32'h432aff97;
            6'd50: v = 32'hab9423a7;
            6'd51: v = 32'hfc93a039;
            6'd52: v = 32'h655b59c3;
            6'd53: v = 32'h8f0ccc92;
            6'd54: v = 32'hffeff47d;
            6'd55: v = 32'h85845dd1;
            6'd56: v = 32'h6fa87e4f;
            6'd57: v = 32'hfe2ce6e0;
            6'd58: v = 32'ha3014314;
            6'd59: v = 32'h4e0811a1;
            6'd60: v = 32'hf7537e82;
            6'd61: v = 32'hbd3af235;
            6'd62: v = 32'h2ad7d2bb;
            6'd63: v = 32'heb86d391;
            default: v = 32'h00000000;
        endcase
        return v;
    endfunction

    // Rotate amount: chosen by round (k[5:4]) and position in round (k[1:0]).
    function automatic logic [4:0] shift_amt(input logic [5:0] k);
        logic [4:0] s;
        case ({k[5:4], k[1:0]})
            4'b00_00: s = 5'd7;
            4'b00_01: s = 5'd12;
            4'b00_10: s = 5'd17;
            4'b00_11: s = 5'd22;
            4'b01_00: s = 5'd5;
            4'b01_01: s = 5'd9;
            4'b01_10: s = 5'd14;
            4'b01_11: s = 5'd20;
            4'b10_00: s = 5'd4;
            4'b10_01: s = 5'd11;
            4'b10_10: s = 5'd16;
            4'b10_11: s = 5'd23;
            4'b11_00: s = 5'd6;
            4'b11_01: s = 5'd10;
            4'b11_10: s = 5'd15;
            4'b11_11: s = 5'd21;
            default:  s = 5'd0;
        endcase
        return s;
    endfunction

    // Message word index; the multipliers are all 0 mod 16 for the round
    // base, so only k mod 16 matters.
    function automatic logic [3:0] msg_index(input logic [5:0] k);
        logic [3:0] kl;
        logic [3:0] g;
        kl = k[3:0];
        case (k[5:4])
            2'd0:    g = kl;
            2'd1:    g = kl * 4'd5 + 4'd1;
            2'd2:    g = kl * 4'd3 + 4'd5;
            2'd3:    g = kl * 4'd7;
            default: g = 4'd0;
        endcase
        return g;
    endfunction

    // Boolean round function on the forward step's (b, c, d) inputs.
    function automatic logic [31:0] round_f(input logic [5:0]  k,
                                            input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] z);
        logic [31:0] f;
        case (k[5:4])
            2'd0:    f = (x & y) | (~x & z);
            2'd1:    f = (x & z) | (y & ~z);
            2'd2:    f = x ^ y ^ z;
            2'd3:    f = y ^ (x | ~z);
            default: f = 32'h00000000;
        endcase
        return f;
    endfunction

    // Rotate right; amounts are always in 4..23, never zero.
    function automatic logic [31:0] rotr32(input logic [31:0] x,
                                           input logic [4:0]  s);
        return (x >> s) | (x << (6'd32 - {1'b0, s}));
    endfunction

    state_t       state_r;
    logic [5:0]   k_r;
    logic [511:0] msg_r;
    logic [31:0]  a_r, b_r, c_r, d_r;
    logic         busy_r;
    logic         done_r;
    logic [31:0]  a_out_r, b_out_r, c_out_r, d_out_r;

    logic [31:0]  load_a_s, load_b_s, load_c_s, load_d_s;
    logic [3:0]   g_s;
    logic [4:0]   s_s;
    logic [31:0]  f_s;
    logic [31:0]  word_s;
    logic [31:0]  a_prev_s;

    // Accept-edge values: either the raw state or the digest minus the IV.
    always_comb begin
        load_a_s = bus.a_in;
        load_b_s = bus.b_in;
        load_c_s = bus.c_in;
        load_d_s = bus.d_in;
        if (bus.ff_sub) begin
            load_a_s = bus.a_in - IV_A;
            load_b_s = bus.b_in - IV_B;
            load_c_s = bus.c_in - IV_C;
            load_d_s = bus.d_in - IV_D;
        end else begin
            load_a_s = bus.a_in;
            load_b_s = bus.b_in;
            load_c_s = bus.c_in;
            load_d_s = bus.d_in;
        end
    end

    // Reverse step k: the forward step left (d, b+rotl(t,s), b, c) behind,
    // so b, c, d come straight back and a is peeled out of the new b.
    always_comb begin
        g_s      = msg_index(k_r);
        s_s      = shift_amt(k_r);
        f_s      = round_f(k_r, c_r, d_r, a_r);
        word_s   = msg_r[{g_s, 5'd0} +: 32];
        a_prev_s = rotr32(b_r - c_r, s_s) - f_s - k_const(k_r) - word_s;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            k_r     <= 6'd0;
            msg_r   <= 512'd0;
            a_r     <= 32'h00000000;
            b_r     <= 32'h00000000;
            c_r     <= 32'h00000000;
            d_r     <= 32'h00000000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            a_out_r <= 32'h00000000;
            b_out_r <= 32'h00000000;
            c_out_r <= 32'h00000000;
            d_out_r <= 32'h00000000;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        msg_r   <= bus.msg;
                        a_r     <= load_a_s;
                        b_r     <= load_b_s;
                        c_r     <= load_c_s;
                        d_r     <= load_d_s;
                        k_r     <= LAST_K;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_r <= a_prev_s;
                    b_r <= c_r;
                    c_r <= d_r;
                    d_r <= a_r;
                    if (k_r == FIRST_K) begin
                        a_out_r <= a_prev_s;
                        b_out_r <= c_r;
                        c_out_r <= d_r;
                        d_out_r <= a_r;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        k_r     <= k_r - 6'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.a_out = a_out_r;
    assign bus.b_out = b_out_r;
    assign bus.c_out = c_out_r;
    assign bus.d_out = d_out_r;

endmodule
